// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between a serial receiver and the CPU bus.
// Each byte presented on the receiver's one-cycle strobe is captured into a
// DEPTH-entry FIFO. The FIFO is exposed through four byte-wide registers:
// DATA (pop), STATUS, CTRL and COUNT. The block tracks overrun and raises a
// level interrupt at a programmable fill threshold.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   rx_data, rx_strobe byte from the receiver, valid only in the strobe cycle
//   addr, rd, wr       register select (0 DATA, 1 STATUS, 2 CTRL, 3 COUNT) and strobes
//   wdata              write data
//   rdata              registered read data, valid the cycle after rd
//   irq                registered level interrupt
module uart_rx_ctrl #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  input  logic [1:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam logic [1:0]  A_DATA   = 2'd0;
  localparam logic [1:0]  A_STATUS = 2'd1;
  localparam logic [1:0]  A_CTRL   = 2'd2;
  localparam logic [1:0]  A_COUNT  = 2'd3;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(IRQ_THRESH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wp_r, rp_r, wp_next_s, rp_next_s;
  logic [AW:0]   count_r, count_next_s;
  logic          overrun_r, overrun_next_s;
  logic          ie_r, ie_next_s;
  logic [7:0]    rdata_r, rdata_next_s;
  logic          irq_r, irq_next_s;
  logic          full_s, empty_s, pop_s, push_s, flush_s, ovf_set_s, ovf_clr_s;

  // Next-state computation for pointers, occupancy, flags and read data
  always_comb begin
    full_s    = (count_r == DEPTH_C);
    empty_s   = (count_r == {(AW+1){1'b0}});
    pop_s     = rd && (addr == A_DATA) && !empty_s;
    flush_s   = wr && (addr == A_CTRL) && wdata[1];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    push_s    = rx_strobe && !flush_s && (!full_s || pop_s);
    ovf_set_s = rx_strobe && !flush_s && full_s && !pop_s;
    ovf_clr_s = wr && (addr == A_STATUS) && wdata[2];

    count_next_s = count_r;
    wp_next_s    = wp_r;
    rp_next_s    = rp_r;
    if (flush_s) begin
      count_next_s = {(AW+1){1'b0}};
      wp_next_s    = {AW{1'b0}};
      rp_next_s    = {AW{1'b0}};
    end else begin
      if (push_s) begin
        wp_next_s = wp_r + PTR_ONE;
      end else begin
        wp_next_s = wp_r;
      end
      if (pop_s) begin
        rp_next_s = rp_r + PTR_ONE;
      end else begin
        rp_next_s = rp_r;
      end
      if (push_s && !pop_s) begin
        count_next_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_next_s = count_r - CNT_ONE;
      end else begin
        count_next_s = count_r;
      end
    end

    // Set wins over a clear landing in the same cycle.
    if (ovf_set_s) begin
      overrun_next_s = 1'b1;
    end else if (ovf_clr_s) begin
      overrun_next_s = 1'b0;
    end else begin
      overrun_next_s = overrun_r;
    end

    if (wr && (addr == A_CTRL)) begin
      ie_next_s = wdata[0];
    end else begin
      ie_next_s = ie_r;
    end

    // Reads see pre-update state, so rd with a CTRL write returns the old ie.
    rdata_next_s = rdata_r;
    if (rd) begin
      case (addr)
        A_DATA:   rdata_next_s = empty_s ? 8'h00 : mem_r[rp_r];
        A_STATUS: rdata_next_s = {4'b0000, irq_r, overrun_r, full_s, !empty_s};
        A_CTRL:   rdata_next_s = {7'b0000000, ie_r};
        A_COUNT:  rdata_next_s = 8'(count_r);
        default:  rdata_next_s = 8'h00;
      endcase
    end else begin
      rdata_next_s = rdata_r;
    end

    irq_next_s = ie_next_s && ((count_next_s >= THRESH_C) || overrun_next_s);
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r      <= {AW{1'b0}};
      rp_r      <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      overrun_r <= 1'b0;
      ie_r      <= 1'b0;
      rdata_r   <= 8'h00;
      irq_r     <= 1'b0;
    end else begin
      wp_r      <= wp_next_s;
      rp_r      <= rp_next_s;
      count_r   <= count_next_s;
      overrun_r <= overrun_next_s;
      ie_r      <= ie_next_s;
      rdata_r   <= rdata_next_s;
      irq_r     <= irq_next_s;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wp_r] <= rx_data;
    end
  end

  assign rdata = rdata_r;
  assign irq   = irq_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a directed vector table for the
// single-operation flows plus hand-written sequences for simultaneous
// push/pop, overrun, flush, reset and pointer wrap-around.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [1:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_ctrl #(.DEPTH(16), .AW(4), .IRQ_THRESH(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .addr(addr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_STB = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_IRQ = 2'd3} op_t;
  typedef struct {
    op_t        op;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_t op, logic [1:0] a, logic [7:0] d, logic [7:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One clock with the given stimulus; outputs are sampled 1 ns after the edge.
  task automatic cyc(logic stb, logic [7:0] b, logic r, logic w, logic [1:0] a, logic [7:0] d);
    rx_strobe = stb; rx_data = b; rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    rx_strobe = 1'b0; rd = 1'b0; wr = 1'b0; rx_data = 8'h00; wdata = 8'h00; addr = 2'd0;
  endtask

  task automatic push(logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic rd_chk(string name, logic [1:0] a, logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, a, 8'h00);
    check(name, rdata, exp);
  endtask

  task automatic wr_reg(logic [1:0] a, logic [7:0] d);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    rst = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00; rd = 1'b0; wr = 1'b0;
    addr = 2'd0; wdata = 8'h00;

    do_reset();
    check("reset_rdata", rdata, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);

    // Single-byte flow and threshold interrupt, table driven
    vecs.push_back(mk(OP_STB, 2'd0, 8'hA5, 8'h00));
    vecs.push_back(mk(OP_RD,  2'd1, 8'h00, 8'h01));
    vecs.push_back(mk(OP_RD,  2'd3, 8'h00, 8'h01));
    vecs.push_back(mk(OP_RD,  2'd0, 8'h00, 8'hA5));
    vecs.push_back(mk(OP_RD,  2'd1, 8'h00, 8'h00));
    vecs.push_back(mk(OP_WR,  2'd2, 8'h01, 8'h00));
    vecs.push_back(mk(OP_IRQ, 2'd0, 8'h00, 8'h00));
    vecs.push_back(mk(OP_STB, 2'd0, 8'h3C, 8'h00));
    vecs.push_back(mk(OP_IRQ, 2'd0, 8'h00, 8'h01));
    vecs.push_back(mk(OP_RD,  2'd2, 8'h00, 8'h01));
    vecs.push_back(mk(OP_RD,  2'd1, 8'h00, 8'h09));
    vecs.push_back(mk(OP_RD,  2'd0, 8'h00, 8'h3C));
    vecs.push_back(mk(OP_IRQ, 2'd0, 8'h00, 8'h00));
    vecs.push_back(mk(OP_WR,  2'd2, 8'h00, 8'h00));
    vecs.push_back(mk(OP_RD,  2'd2, 8'h00, 8'h00));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_STB: push(vecs[i].d);
        OP_RD:  rd_chk($sformatf("vec%0d_rd", i), vecs[i].a, vecs[i].exp);
        OP_WR:  wr_reg(vecs[i].a, vecs[i].d);
        OP_IRQ: check($sformatf("vec%0d_irq", i), {7'd0, irq}, vecs[i].exp);
        default: ;
      endcase
    end

    // Fill, overflow, set-wins-over-clear, drain in order, clear overrun
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    rd_chk("ovf_status", 2'd1, 8'h07);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 2'd1, 8'h04);
    rd_chk("ovf_set_wins", 2'd1, 8'h07);
    rd_chk("full_count", 2'd3, 8'h10);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("drain%0d", i), 2'd0, 8'(i));
    rd_chk("drained_status", 2'd1, 8'h04);
    wr_reg(2'd1, 8'h04);
    rd_chk("ovf_cleared", 2'd1, 8'h00);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 16; i++) push(8'(i));
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 8'h00);
    check("full_pushpop_rdata", rdata, 8'h00);
    rd_chk("full_pushpop_status", 2'd1, 8'h03);
    rd_chk("full_pushpop_count", 2'd3, 8'h10);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("fp_drain%0d", i), 2'd0, 8'(i));
    rd_chk("fp_last", 2'd0, 8'h55);
    rd_chk("empty_pop", 2'd0, 8'h00);

    // Empty FIFO: push and pop in the same cycle
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 2'd0, 8'h00);
    check("empty_pushpop_rdata", rdata, 8'h00);
    rd_chk("empty_pushpop_count", 2'd3, 8'h01);
    rd_chk("empty_pushpop_data", 2'd0, 8'h77);

    // Flush coinciding with a strobe
    push(8'h11); push(8'h22); push(8'h33);
    cyc(1'b1, 8'h44, 1'b0, 1'b1, 2'd2, 8'h02);
    rd_chk("flush_count", 2'd3, 8'h00);
    rd_chk("flush_status", 2'd1, 8'h00);
    rd_chk("flush_data", 2'd0, 8'h00);

    // CTRL read with write in the same cycle; DATA writes ignored
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h01);
    check("ctrl_prewrite", rdata, 8'h00);
    rd_chk("ctrl_postwrite", 2'd2, 8'h01);
    wr_reg(2'd0, 8'h99);
    rd_chk("data_wr_ignored", 2'd3, 8'h00);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    check("pre_rst_irq", {7'd0, irq}, 8'h01);
    do_reset();
    check("rst_irq", {7'd0, irq}, 8'h00);
    rd_chk("rst_count", 2'd3, 8'h00);
    rd_chk("rst_status", 2'd1, 8'h00);
    rd_chk("rst_ctrl", 2'd2, 8'h00);

    // Pointer wrap: three bytes in flight across 40 push+pop cycles
    for (int i = 0; i < 3; i++) begin
      b = 8'(8'hD0 + i);
      push(b);
      q.push_back(b);
    end
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 13 + 7);
      cyc(1'b1, b, 1'b1, 1'b0, 2'd0, 8'h00);
      check($sformatf("wrap%0d", i), rdata, q.pop_front());
      q.push_back(b);
    end
    rd_chk("wrap_count", 2'd3, 8'h03);
    for (int i = 0; i < 3; i++) rd_chk($sformatf("wrap_tail%0d", i), 2'd0, q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
